uart_rx_oversampler: RTL and testbench



---
 rtl/uart_rx_oversampler.sv | 154 +++++++++++++++
 tb/tb_uart_rx_oversampler.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversampler.sv
// rtl/uart_rx_oversampler.sv - 8N1 UART receiver driven by a 16x oversampling tick
`timescale 1ns/1ps

module uart_rx_oversampler #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 UART_clk,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 framing_err,
    output logic                 busy
);

    localparam logic [3:0] MID_SAMPLE = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] END_SAMPLE = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] LAST_BIT   = 3'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic                 rx_meta;
    logic                 rx_s;
    logic                 uclk_meta;
    logic                 uclk_s;
    logic                 uclk_h;
    logic                 tick;

    state_t               state;
    state_t               state_n;
    logic [3:0]           scnt;
    logic [3:0]           scnt_n;
    logic [2:0]           bit_idx;
    logic [2:0]           bit_idx_n;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] shreg_n;
    logic [DATA_BITS-1:0] rx_data_n;
    logic                 rx_valid_n;
    logic                 framing_err_n;

    // rx idles high, so its synchronizer resets high to avoid a phantom start bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            uclk_meta <= 1'b0;
            uclk_s    <= 1'b0;
            uclk_h    <= 1'b0;
        end else begin
            rx_meta   <= rx;
            rx_s      <= rx_meta;
            uclk_meta <= UART_clk;
            uclk_s    <= uclk_meta;
            uclk_h    <= uclk_s;
        end
    end

    assign tick = uclk_s & ~uclk_h;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            scnt        <= 4'd0;
            bit_idx     <= 3'd0;
            shreg       <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            state       <= state_n;
            scnt        <= scnt_n;
            bit_idx     <= bit_idx_n;
            shreg       <= shreg_n;
            rx_data     <= rx_data_n;
            rx_valid    <= rx_valid_n;
            framing_err <= framing_err_n;
        end
    end

    always_comb begin
        state_n       = state;
        scnt_n        = scnt;
        bit_idx_n     = bit_idx;
        shreg_n       = shreg;
        rx_data_n     = rx_data;
        rx_valid_n    = 1'b0;
        framing_err_n = 1'b0;

        if (tick) begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state_n = START;
                        scnt_n  = 4'd0;
                    end
                end
                START: begin
                    if (scnt == MID_SAMPLE) begin
                        if (!rx_s) begin
                            state_n   = DATA;
                            scnt_n    = 4'd0;
                            bit_idx_n = 3'd0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        scnt_n = scnt + 4'd1;
                    end
                end
                DATA: begin
                    // Shifting in at the MSB leaves the first (LSB) bit at bit 0
                    if (scnt == END_SAMPLE) begin
                        shreg_n   = {rx_s, shreg[DATA_BITS-1:1]};
                        scnt_n    = 4'd0;
                        bit_idx_n = bit_idx + 3'd1;
                        if (bit_idx == LAST_BIT) begin
                            state_n = STOP;
                        end
                    end else begin
                        scnt_n = scnt + 4'd1;
                    end
                end
                STOP: begin
                    // Leaving at mid-stop lets IDLE catch a start edge that follows immediately
                    if (scnt == END_SAMPLE) begin
                        if (rx_s) begin
                            rx_data_n  = shreg;
                            rx_valid_n = 1'b1;
                        end else begin
                            framing_err_n = 1'b1;
                        end
                        state_n = IDLE;
                        scnt_n  = 4'd0;
                    end else begin
                        scnt_n = scnt + 4'd1;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_oversampler.sv
// tb/tb_uart_rx_oversampler.sv - scoreboard bench for uart_rx_oversampler
`timescale 1ns/1ps

module tb_uart_rx_oversampler;

    localparam int CLK_HALF = 5;
    localparam int TICK_NS  = 80;
    localparam int BIT_NS   = 16 * TICK_NS;
    localparam int SLOW_NS  = 1318;
    localparam int LAT_MIN  = 152 * TICK_NS;
    localparam int LAT_MAX  = LAT_MIN + 320;

    logic       clk;
    logic       rst;
    logic       UART_clk;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       framing_err;
    logic       busy;

    typedef struct {
        logic       err;
        logic [7:0] data;
        time        t0;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   failures;

    uart_rx_oversampler #(
        .DATA_BITS (8),
        .OVERSAMPLE(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .UART_clk   (UART_clk),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .framing_err(framing_err),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #(CLK_HALF) clk = ~clk;
    end

    initial begin
        UART_clk = 1'b0;
        forever #(TICK_NS / 2) UART_clk = ~UART_clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic expect_byte(input logic err, input logic [7:0] data, input time t0);
        exp_t e;
        e.err  = err;
        e.data = data;
        e.t0   = t0;
        exp_q.push_back(e);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int bit_ns);
        rx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            #(bit_ns);
        end
        rx = stop_bit;
        #(bit_ns);
        rx = 1'b1;
    endtask

    task automatic monitor();
        logic pend;
        exp_t e;
        time  dt;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (pend) begin
                chk("pulse_width_one_clk", {30'd0, rx_valid, framing_err}, 32'd0);
                pend = 1'b0;
            end
            if (rx_valid || framing_err) begin
                pend = 1'b1;
                chk("valid_err_exclusive", {31'd0, rx_valid & framing_err}, 32'd0);
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_pulse actual rx_valid=%0b framing_err=%0b rx_data=0x%0h required no pulse",
                             rx_valid, framing_err, rx_data);
                end else begin
                    e = exp_q.pop_front();
                    if (e.err) begin
                        chk("framing_err_kind", {31'd0, framing_err}, 32'd1);
                        chk("rx_data_held", {24'd0, rx_data}, {24'd0, e.data});
                    end else begin
                        chk("rx_valid_kind", {31'd0, rx_valid}, 32'd1);
                        chk("rx_data", {24'd0, rx_data}, {24'd0, e.data});
                    end
                    if (e.t0 != 0) begin
                        dt = $time - e.t0;
                        checks++;
                        if (dt < LAT_MIN || dt > LAT_MAX) begin
                            failures++;
                            $display("FAIL start_to_valid_latency actual=%0t required=%0d..%0d ns", dt, LAT_MIN, LAT_MAX);
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        rx       = 1'b1;
        fork
            monitor();
        join_none

        repeat (5) @(negedge clk);
        chk("reset_rx_data", {24'd0, rx_data}, 32'd0);
        chk("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("reset_framing_err", {31'd0, framing_err}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        #(2 * BIT_NS);

        // Good frame with start-to-valid latency check
        expect_byte(1'b0, 8'hA5, $time);
        send_frame(8'hA5, 1'b1, BIT_NS);
        #(2 * BIT_NS);
        chk("busy_idle_after_a5", {31'd0, busy}, 32'd0);

        // Good frame, then a frame whose stop bit is low
        expect_byte(1'b0, 8'h11, 0);
        send_frame(8'h11, 1'b1, BIT_NS);
        #(BIT_NS);
        expect_byte(1'b1, 8'h11, 0);
        send_frame(8'h3C, 1'b0, BIT_NS);
        #(3 * BIT_NS);
        chk("rx_data_after_ferr", {24'd0, rx_data}, 32'h11);
        chk("busy_idle_after_ferr", {31'd0, busy}, 32'd0);

        // Four-tick glitch is a false start
        rx = 1'b0;
        #250;
        chk("busy_during_glitch", {31'd0, busy}, 32'd1);
        #(4 * TICK_NS - 250);
        rx = 1'b1;
        #(12 * TICK_NS);
        chk("busy_after_glitch", {31'd0, busy}, 32'd0);
        chk("rx_data_after_glitch", {24'd0, rx_data}, 32'h11);
        #(2 * BIT_NS);

        // Back-to-back frames without idle gap
        expect_byte(1'b0, 8'h00, 0);
        expect_byte(1'b0, 8'hFF, 0);
        send_frame(8'h00, 1'b1, BIT_NS);
        send_frame(8'hFF, 1'b1, BIT_NS);
        #(2 * BIT_NS);
        chk("rx_data_after_b2b", {24'd0, rx_data}, 32'hFF);

        // Reset during data bit 3; held until the aborted frame has left the line
        fork
            send_frame(8'h96, 1'b1, BIT_NS);
        join_none
        #(4 * BIT_NS + BIT_NS / 2);
        chk("busy_mid_frame", {31'd0, busy}, 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_rx_data", {24'd0, rx_data}, 32'd0);
        chk("midrst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("midrst_framing_err", {31'd0, framing_err}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        #(6 * BIT_NS);
        @(negedge clk);
        rst = 1'b0;
        #(BIT_NS);
        expect_byte(1'b0, 8'h5A, 0);
        send_frame(8'h5A, 1'b1, BIT_NS);
        #(2 * BIT_NS);
        chk("rx_data_after_reset_frame", {24'd0, rx_data}, 32'h5A);

        // Bit periods 3% longer than nominal
        expect_byte(1'b0, 8'hC3, 0);
        send_frame(8'hC3, 1'b1, SLOW_NS);
        #(3 * BIT_NS);
        chk("rx_data_slow_baud", {24'd0, rx_data}, 32'hC3);
        chk("busy_final", {31'd0, busy}, 32'd0);
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
